// File: rtl/key_press_classifier.sv
// Debounces the active-low KEY button and times each press in whole seconds.
// On release, emits a one-cycle CMD_VALID with STOP/LEFT/RIGHT and the hold time.
module key_press_classifier #(
   parameter int TICKS_PER_SEC   = 50_000_000,
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int LEFT_MIN_S      = 1,
   parameter int RIGHT_MIN_S     = 4
) (
   input  logic       CLOCK_50Mhz,
   input  logic       RESET_N,
   input  logic       KEY,
   output logic       KEY_DOWN,
   output logic [1:0] CMD,
   output logic       CMD_VALID,
   output logic [3:0] PRESS_SEC
);

   localparam int DIV_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam int DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

   localparam logic [DIV_W-1:0] DIV_MAX   = DIV_W'(TICKS_PER_SEC - 1);
   localparam logic [DEB_W-1:0] DEB_MAX   = DEB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [3:0]       LEFT_MIN  = 4'(LEFT_MIN_S);
   localparam logic [3:0]       RIGHT_MIN = 4'(RIGHT_MIN_S);
   localparam logic [3:0]       SEC_MAX   = 4'd15;

   localparam logic [1:0] CMD_STOP  = 2'b00;
   localparam logic [1:0] CMD_LEFT  = 2'b01;
   localparam logic [1:0] CMD_RIGHT = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE,
      S_PRESSED,
      S_REPORT
   } state_t;

   state_t           state_q;
   logic             key_meta_q;
   logic             key_sync_q;
   logic             key_down_q;
   logic             key_down_d;
   logic [DEB_W-1:0] deb_cnt_q;
   logic [DEB_W-1:0] deb_cnt_d;
   logic [DIV_W-1:0] div_q;
   logic [DIV_W-1:0] div_d;
   logic [3:0]       sec_q;
   logic [3:0]       sec_d;
   logic [1:0]       cmd_q;
   logic [1:0]       cmd_d;
   logic             cmd_valid_q;
   logic [3:0]       press_sec_q;
   logic             key_pressed;
   logic             div_wrap;

   assign key_pressed = ~key_sync_q;

   // NOTE: every combinational output gets a default first so no path can infer a latch.
   always_comb begin
      deb_cnt_d  = '0;
      key_down_d = key_down_q;
      if (key_pressed != key_down_q) begin
         if (deb_cnt_q == DEB_MAX) begin
            key_down_d = ~key_down_q;
         end else begin
            deb_cnt_d = deb_cnt_q + 1'b1;
         end
      end
   end

   // Timing for the current PRESSED cycle, so the exit cycle is counted too.
   always_comb begin
      div_wrap = (div_q == DIV_MAX);
      div_d    = div_wrap ? '0 : div_q + 1'b1;
      sec_d    = (div_wrap && sec_q != SEC_MAX) ? sec_q + 4'd1 : sec_q;
      if (sec_d < LEFT_MIN) begin
         cmd_d = CMD_STOP;
      end else if (sec_d < RIGHT_MIN) begin
         cmd_d = CMD_LEFT;
      end else begin
         cmd_d = CMD_RIGHT;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
   always_ff @(posedge CLOCK_50Mhz) begin
      if (!RESET_N) begin
         state_q     <= S_IDLE;
         key_meta_q  <= 1'b1;
         key_sync_q  <= 1'b1;
         key_down_q  <= 1'b0;
         deb_cnt_q   <= '0;
         div_q       <= '0;
         sec_q       <= '0;
         cmd_q       <= CMD_STOP;
         cmd_valid_q <= 1'b0;
         press_sec_q <= '0;
      end else begin
         key_meta_q  <= KEY;
         key_sync_q  <= key_meta_q;
         key_down_q  <= key_down_d;
         deb_cnt_q   <= deb_cnt_d;
         cmd_valid_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (key_down_q) begin
                  state_q <= S_PRESSED;
                  div_q   <= '0;
                  sec_q   <= '0;
               end
            end
            S_PRESSED: begin
               div_q <= div_d;
               sec_q <= sec_d;
               if (!key_down_q) begin
                  state_q     <= S_REPORT;
                  cmd_valid_q <= 1'b1;
                  cmd_q       <= cmd_d;
                  press_sec_q <= sec_d;
               end
            end
            S_REPORT: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign KEY_DOWN  = key_down_q;
   assign CMD       = cmd_q;
   assign CMD_VALID = cmd_valid_q;
   assign PRESS_SEC = press_sec_q;

endmodule

// File: tb/tb_key_press_classifier.sv
// Self-checking bench for key_press_classifier with small timing parameters.
// Table-driven presses feed a scoreboard that a negedge monitor drains on CMD_VALID.
module tb_key_press_classifier;

   localparam int TPS  = 10;
   localparam int DEB  = 4;
   localparam int LMIN = 1;
   localparam int RMIN = 4;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       key   = 1'b1;
   logic       key_down;
   logic [1:0] cmd;
   logic       cmd_valid;
   logic [3:0] press_sec;

   always #5 clk = ~clk;

   key_press_classifier #(
      .TICKS_PER_SEC  (TPS),
      .DEBOUNCE_CYCLES(DEB),
      .LEFT_MIN_S     (LMIN),
      .RIGHT_MIN_S    (RMIN)
   ) dut (
      .CLOCK_50Mhz(clk),
      .RESET_N    (rst_n),
      .KEY        (key),
      .KEY_DOWN   (key_down),
      .CMD        (cmd),
      .CMD_VALID  (cmd_valid),
      .PRESS_SEC  (press_sec)
   );

   typedef struct packed {
      logic [1:0] cmd;
      logic [3:0] sec;
   } exp_t;

   typedef struct {
      int         hold;
      bit         bounce;
      logic [1:0] cmd;
      logic [3:0] sec;
   } vec_t;

   exp_t sb_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Scoreboard drain: each CMD_VALID cycle must match exactly one queued press.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (rst_n && cmd_valid === 1'b1) begin
         if (sb_q.size() == 0) begin
            check("spurious_valid", {31'd0, cmd_valid}, 32'd0);
         end else begin
            e = sb_q.pop_front();
            check("cmd", {30'd0, cmd}, {30'd0, e.cmd});
            check("press_sec", {28'd0, press_sec}, {28'd0, e.sec});
         end
      end
   end

   // Called at a negedge; hold counts raw KEY-low cycles from first press to final release.
   task automatic press(input int hold, input bit bounce, input logic [1:0] ecmd,
                        input logic [3:0] esec, input string name);
      int lat;
      bit seen;
      sb_q.push_back('{ecmd, esec});
      key = 1'b0;
      if (bounce) begin
         repeat (hold - 4) @(negedge clk);
         key = 1'b1;
         repeat (2) @(negedge clk);
         key = 1'b0;
         repeat (2) @(negedge clk);
      end else begin
         repeat (hold) @(negedge clk);
      end
      key  = 1'b1;
      seen = 1'b0;
      lat  = 0;
      for (int i = 1; i <= 20 && !seen; i++) begin
         @(negedge clk);
         if (cmd_valid === 1'b1) begin
            seen = 1'b1;
            lat  = i;
         end
      end
      check({name, "_latency"}, lat, 7);
      repeat (2) @(negedge clk);
      check({name, "_valid_low"}, {31'd0, cmd_valid}, 32'd0);
      check({name, "_cmd_hold"}, {30'd0, cmd}, {30'd0, ecmd});
   endtask

   vec_t vecs[9];

   initial begin
      int  k;
      bit  kd_seen;
      bit  seen;

      vecs[0] = '{8,   1'b0, 2'b00, 4'd0};
      vecs[1] = '{9,   1'b0, 2'b00, 4'd0};
      vecs[2] = '{10,  1'b0, 2'b01, 4'd1};
      vecs[3] = '{19,  1'b1, 2'b01, 4'd1};
      vecs[4] = '{35,  1'b1, 2'b01, 4'd3};
      vecs[5] = '{39,  1'b0, 2'b01, 4'd3};
      vecs[6] = '{40,  1'b0, 2'b10, 4'd4};
      vecs[7] = '{55,  1'b0, 2'b10, 4'd5};
      vecs[8] = '{200, 1'b0, 2'b10, 4'd15};

      // Reset with the key held down.
      rst_n = 1'b0;
      key   = 1'b0;
      repeat (5) @(negedge clk);
      check("rst_key_down", {31'd0, key_down}, 32'd0);
      check("rst_cmd", {30'd0, cmd}, 32'd0);
      check("rst_cmd_valid", {31'd0, cmd_valid}, 32'd0);
      check("rst_press_sec", {28'd0, press_sec}, 32'd0);
      key   = 1'b1;
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // Glitch one cycle shorter than the debounce window.
      kd_seen = 1'b0;
      key = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (key_down) kd_seen = 1'b1;
      end
      key = 1'b1;
      repeat (10) begin
         @(negedge clk);
         if (key_down) kd_seen = 1'b1;
      end
      check("glitch_key_down", {31'd0, kd_seen}, 32'd0);

      for (int i = 0; i < 9; i++) begin
         press(vecs[i].hold, vecs[i].bounce, vecs[i].cmd, vecs[i].sec, $sformatf("vec%0d", i));
         repeat (3) @(negedge clk);
      end

      // Reset in the middle of a hold; the old press must vanish.
      key = 1'b0;
      k = 0;
      while (key_down !== 1'b1 && k < 20) begin
         @(negedge clk);
         k++;
      end
      check("rmp_first_rise", {31'd0, key_down}, 32'd1);
      repeat (30) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("rmp_key_down", {31'd0, key_down}, 32'd0);
      check("rmp_cmd", {30'd0, cmd}, 32'd0);
      check("rmp_press_sec", {28'd0, press_sec}, 32'd0);
      k = 0;
      while (key_down !== 1'b1 && k < 20) begin
         @(negedge clk);
         k++;
      end
      check("rmp_rise_delay", k, 6);
      check("rmp_cmd_after", {30'd0, cmd}, 32'd0);
      sb_q.push_back('{2'b01, 4'd1});
      repeat (12) @(negedge clk);
      key  = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (cmd_valid === 1'b1) seen = 1'b1;
      end
      check("rmp_pulse_seen", {31'd0, seen}, 32'd1);
      repeat (4) @(negedge clk);

      check("scoreboard_empty", sb_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
